// File: rtl/adder_acc_pkg.sv
// rtl/adder_acc_pkg.sv - shared state encoding and default sizes for the adder accumulator
package adder_acc_pkg;

  localparam int ACC_WIDTH   = 16;
  localparam int ACC_CNT_W   = 8;
  localparam int ACC_CARRY_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_e;

endpackage

// File: rtl/acc_adder16.sv
// rtl/acc_adder16.sv - combinational WIDTH-bit carry-propagate add with carry-in and carry-out
module acc_adder16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};

endmodule

// File: rtl/adder_accumulator.sv
// rtl/adder_accumulator.sv - streaming operand accumulator with carry-out count; ADDER_ACC_SATURATE_EN clamps the sum
module adder_accumulator
  import adder_acc_pkg::*;
#(
  parameter int WIDTH   = ACC_WIDTH,
  parameter int CNT_W   = ACC_CNT_W,
  parameter int CARRY_W = ACC_CARRY_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   len,
  input  logic               cin,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_sum,
  output logic [CARRY_W-1:0] out_carries
);

  acc_state_e          state_q, state_d;
  logic [WIDTH-1:0]    acc_q, acc_d;
  logic [CARRY_W-1:0]  carries_q, carries_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;

  logic [WIDTH-1:0]    add_s;
  logic                add_co;
  logic                beat;

  acc_adder16 #(.WIDTH(WIDTH)) u_add (
    .a  (acc_q),
    .b  (in_data),
    .ci (1'b0),
    .s  (add_s),
    .co (add_co)
  );

  assign beat = in_valid && (state_q == ACCUM);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    carries_d   = carries_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d       = {{(WIDTH-1){1'b0}}, cin};
          carries_d   = '0;
          remaining_d = len;
          state_d     = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
`ifdef ADDER_ACC_SATURATE_EN
          // Once clamped, later adds of zero keep all-ones and nonzero adds carry again.
          acc_d = add_co ? {WIDTH{1'b1}} : add_s;
`else
          acc_d = add_s;
`endif
          if (add_co && (carries_q != {CARRY_W{1'b1}})) begin
            carries_d = carries_q + CARRY_W'(1);
          end
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      carries_q   <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      carries_q   <= carries_d;
      remaining_q <= remaining_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign in_ready    = (state_q == ACCUM);
  assign out_valid   = (state_q == DONE);
  assign out_sum     = acc_q;
  assign out_carries = carries_q;

endmodule

// File: tb/tb_adder_accumulator.sv
// tb/tb_adder_accumulator.sv - scoreboard bench for adder_accumulator; honours ADDER_ACC_SATURATE_EN
module tb_adder_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        cin;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic [7:0]  out_carries;

  int vec_cnt = 0;
  int miscmp  = 0;

  logic [23:0] sb_q[$];
  logic [15:0] job_data[0:255];

  adder_accumulator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .len         (len),
    .cin         (cin),
    .busy        (busy),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_carries (out_carries)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},    32'(busy),        32'd0);
    check({tag, "_inrdy"},   32'(in_ready),    32'd0);
    check({tag, "_outvld"},  32'(out_valid),   32'd0);
    check({tag, "_sum"},     32'(out_sum),     32'd0);
    check({tag, "_carries"}, 32'(out_carries), 32'd0);
  endtask

  // Drive one job from job_data[0..n-1], model it, then handshake the result.
  task automatic run_job(input int n, input logic c, input int gap_pct,
                         input int hold, input logic start_in_hold);
    logic [15:0] acc_m;
    logic [7:0]  car_m;
    logic [16:0] t;
    logic [23:0] exp;
    int          guard;
    guard = 0;
    while (busy && guard < 1000) begin
      tick();
      guard++;
    end
    check("idle_before_start", 32'(busy), 32'd0);
    start = 1'b1;
    len   = n[7:0];
    cin   = c;
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    acc_m = {15'b0, c};
    car_m = 8'd0;
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        tick();
      end
      check("in_ready_accum", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = job_data[i];
      tick();
      in_valid = 1'b0;
      t = {1'b0, acc_m} + {1'b0, job_data[i]};
`ifdef ADDER_ACC_SATURATE_EN
      acc_m = t[16] ? 16'hFFFF : t[15:0];
`else
      acc_m = t[15:0];
`endif
      if (t[16] && car_m != 8'hFF) car_m = car_m + 8'd1;
    end
    sb_q.push_back({car_m, acc_m});
    check("out_valid_latency", 32'(out_valid), 32'd1);
    guard = 0;
    while (!out_valid && guard < 50) begin
      tick();
      guard++;
    end
    exp = sb_q.pop_front();
    check("result", {8'd0, out_carries, out_sum}, {8'd0, exp});
    for (int h = 0; h < hold; h++) begin
      if (start_in_hold) begin
        start = 1'b1;
        len   = 8'($urandom_range(255));
        cin   = ~c;
      end
      tick();
      check("hold_valid",  32'(out_valid), 32'd1);
      check("hold_inrdy",  32'(in_ready),  32'd0);
      check("hold_result", {8'd0, out_carries, out_sum}, {8'd0, exp});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("busy_after_ack",  32'(busy),      32'd0);
    check("valid_after_ack", 32'(out_valid), 32'd0);
    if (start_in_hold) begin
      start = 1'b0;
      tick();
      check("start_ignored", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = 8'd0;
    cin       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'd0;
    out_ready = 1'b0;
    tick();
    tick();
    check_idle("in_reset");
    rst_n = 1'b1;
    tick();
    tick();
    check_idle("after_reset");

    job_data[0] = 16'd100;
    job_data[1] = 16'd200;
    job_data[2] = 16'd300;
    run_job(3, 1'b1, 0, 0, 1'b0);

    job_data[0] = 16'hFFFF;
    job_data[1] = 16'h0002;
    run_job(2, 1'b0, 0, 0, 1'b0);

    run_job(0, 1'b1, 0, 0, 1'b0);

    job_data[0] = 16'h1234;
    run_job(1, 1'b0, 0, 5, 1'b1);

    for (int i = 0; i < 255; i++) job_data[i] = 16'hFFFF;
    run_job(255, 1'b0, 0, 0, 1'b0);

    // Abort mid-job: outputs must clear without waiting for a clock edge.
    start = 1'b1;
    len   = 8'd5;
    cin   = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h4321;
    tick();
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_abort");
    tick();
    rst_n = 1'b1;
    tick();
    check_idle("after_abort");

    for (int j = 0; j < 3000; j++) begin
      int n;
      n = ($urandom_range(9) == 0) ? int'($urandom_range(40)) : int'($urandom_range(6));
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(3))
          0:       job_data[i] = 16'($urandom_range(255));
          1:       job_data[i] = 16'hFF00 | 16'($urandom_range(255));
          default: job_data[i] = 16'($urandom);
        endcase
      end
      run_job(n, 1'($urandom_range(1)), 30, int'($urandom_range(2)),
              ($urandom_range(7) == 0));
    end

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule
